// File: rtl/prog_mem_streamer_if.sv
// prog_mem_streamer_if
//   Groups the load port, the fetch controls and the instruction stream
//   between a program loader/consumer and prog_mem_streamer.
//
//   Load port : wr_en, wr_addr, wr_data
//   Controls  : start, step_en, jump_en, jump_addr
//   Stream    : addr, DIN, din_valid
//   Status    : busy, done
//
//   master : the side that loads the program and consumes the stream
//   slave  : the streamer itself
`timescale 1ns/1ps

interface prog_mem_streamer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              step_en;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] DIN;
  logic              din_valid;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, start, step_en, jump_en, jump_addr,
    input  addr, DIN, din_valid, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, step_en, jump_en, jump_addr,
    output addr, DIN, din_valid, busy, done
  );

endinterface

// File: rtl/prog_mem_streamer.sv
// prog_mem_streamer
//   Program memory (2**ADDR_W x DATA_W) with a built-in fetch sequencer
//   that presents one registered instruction word (DIN) and its address
//   to the processor. The consumer advances with step_en, can redirect
//   with jump_en, and the end of the program either wraps to 0 (WRAP=1)
//   or halts in DONE (WRAP=0).
//
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset (memory contents kept)
//     bus      prog_mem_streamer_if.slave: load port, controls, stream,
//              busy/done status
`timescale 1ns/1ps

module prog_mem_streamer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter bit WRAP   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  prog_mem_streamer_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RUN,
    DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              load;
  logic [ADDR_W-1:0] rd_addr;
  logic              next_valid;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Next read address and state are decided combinationally so that the
  // synchronous read lands DIN and addr on the very same edge. This is
  // what gives zero-bubble streaming while step_en is held.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    rd_addr    = bus.addr;
    next_valid = bus.din_valid;
    unique case (state)
      IDLE: begin
        if (bus.start) next_state = FETCH;
      end
      FETCH: begin
        load       = 1'b1;
        rd_addr    = '0;
        next_valid = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        // Jump outranks step; a step on the same cycle is dropped.
        if (bus.jump_en) begin
          load    = 1'b1;
          rd_addr = bus.jump_addr;
        end else if (bus.step_en) begin
          if (bus.addr == LAST_ADDR && !WRAP) begin
            next_state = DONE;
            next_valid = 1'b0;
          end else begin
            // Modulo arithmetic makes LAST_ADDR+1 roll over to 0.
            load    = 1'b1;
            rd_addr = bus.addr + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        if (bus.start) next_state = FETCH;
      end
      default: next_state = IDLE;
    endcase
  end

  // The array has no reset so a program survives reset_n.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end

  // DIN doubles as the memory read register. Because the array update is
  // non-blocking, a same-cycle write to rd_addr returns the old word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bus.addr      <= '0;
      bus.DIN       <= '0;
      bus.din_valid <= 1'b0;
    end else begin
      state         <= next_state;
      bus.din_valid <= next_valid;
      if (load) begin
        bus.addr <= rd_addr;
        bus.DIN  <= mem[rd_addr];
      end
    end
  end

  assign bus.busy = (state == FETCH) || (state == RUN);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_prog_mem_streamer.sv
// tb_prog_mem_streamer
//   Directed bench driving a wrapping (WRAP=1) and a halting (WRAP=0)
//   streamer with identical stimulus and comparing both against
//   hand-computed expectations.
`timescale 1ns/1ps

module tb_prog_mem_streamer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              step_en;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;

  int num_checks = 0;
  int num_fails  = 0;

  prog_mem_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_w ();
  prog_mem_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_h ();

  // Both devices see exactly the same inputs.
  assign bus_w.wr_en     = wr_en;
  assign bus_w.wr_addr   = wr_addr;
  assign bus_w.wr_data   = wr_data;
  assign bus_w.start     = start;
  assign bus_w.step_en   = step_en;
  assign bus_w.jump_en   = jump_en;
  assign bus_w.jump_addr = jump_addr;
  assign bus_h.wr_en     = wr_en;
  assign bus_h.wr_addr   = wr_addr;
  assign bus_h.wr_data   = wr_data;
  assign bus_h.start     = start;
  assign bus_h.step_en   = step_en;
  assign bus_h.jump_en   = jump_en;
  assign bus_h.jump_addr = jump_addr;

  prog_mem_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRAP(1'b1)) dut_wrap (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_w.slave)
  );

  prog_mem_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRAP(1'b0)) dut_halt (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_h.slave)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set the fetch controls, then advance one clock.
  task automatic applyStimulus(input logic s, input logic st, input logic j,
                               input logic [ADDR_W-1:0] ja);
    start     = s;
    step_en   = st;
    jump_en   = j;
    jump_addr = ja;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    start     = 1'b1;
    step_en   = 1'b0;
    jump_en   = 1'b0;
    jump_addr = '0;

    // Reset held with start asserted.
    #20;
    checkOutput("rst_addr",  bus_w.addr, 0);
    checkOutput("rst_din",   bus_w.DIN, 0);
    checkOutput("rst_valid", bus_w.din_valid, 0);
    checkOutput("rst_busy",  bus_w.busy, 0);
    checkOutput("rst_done",  bus_h.done, 0);
    checkOutput("rst_din_h", bus_h.DIN, 0);

    @(posedge clk);
    #1;
    reset_n = 1'b1;
    start   = 1'b0;
    tick();
    tick();
    checkOutput("idle_busy",  bus_w.busy, 0);
    checkOutput("idle_valid", bus_h.din_valid, 0);

    // Load the program image.
    for (int i = 0; i < 32; i++) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(i);
      wr_data = DATA_W'(16'hA000 + i);
      tick();
    end
    wr_en = 1'b0;

    // Jump while idle has no effect.
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd20);
    checkOutput("idle_jump_addr", bus_w.addr, 0);
    checkOutput("idle_jump_busy", bus_w.busy, 0);
    jump_en = 1'b0;

    // Start: FETCH after one edge, RUN with word 0 after the second.
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    checkOutput("fetch_busy",  bus_w.busy, 1);
    checkOutput("fetch_valid", bus_w.din_valid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    checkOutput("run_valid", bus_w.din_valid, 1);
    checkOutput("run_addr",  bus_w.addr, 0);
    checkOutput("run_din",   bus_w.DIN, 16'hA000);

    // Streaming with step_en held: one word per clock.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
      checkOutput("stream_addr", bus_w.addr, k);
      checkOutput("stream_din",  bus_h.DIN, 16'hA000 + k);
    end

    // Stall for three cycles at addr 5.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
      checkOutput("stall_addr", bus_w.addr, 5);
      checkOutput("stall_din",  bus_w.DIN, 16'hA005);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    checkOutput("resume_addr", bus_w.addr, 6);
    checkOutput("resume_din",  bus_w.DIN, 16'hA006);

    // Write mem[7] while stepping from 6 to 7: old word is returned.
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 16'hBEEF;
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    wr_en = 1'b0;
    checkOutput("rbw_addr", bus_w.addr, 7);
    checkOutput("rbw_din",  bus_w.DIN, 16'hA007);

    // Jump beats step.
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd3);
    checkOutput("jump3_addr", bus_w.addr, 3);
    checkOutput("jump3_din",  bus_w.DIN, 16'hA003);
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd20);
    checkOutput("jump20_addr",  bus_w.addr, 20);
    checkOutput("jump20_din",   bus_w.DIN, 16'hA014);
    checkOutput("jump20_valid", bus_w.din_valid, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd7);
    checkOutput("revisit_din", bus_w.DIN, 16'hBEEF);

    // Step from 7 up to the last address.
    for (int k = 8; k <= 31; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    end
    checkOutput("last_addr",   bus_w.addr, 31);
    checkOutput("last_din",    bus_h.DIN, 16'hA01F);

    // One more step: wrap vs halt.
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    checkOutput("wrap_addr",   bus_w.addr, 0);
    checkOutput("wrap_din",    bus_w.DIN, 16'hA000);
    checkOutput("wrap_busy",   bus_w.busy, 1);
    checkOutput("wrap_done",   bus_w.done, 0);
    checkOutput("halt_done",   bus_h.done, 1);
    checkOutput("halt_valid",  bus_h.din_valid, 0);
    checkOutput("halt_addr",   bus_h.addr, 31);
    checkOutput("halt_din",    bus_h.DIN, 16'hA01F);
    checkOutput("halt_busy",   bus_h.busy, 0);

    // Jump ignored in DONE, honoured in RUN.
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd20);
    checkOutput("done_jump_addr", bus_h.addr, 31);
    checkOutput("done_jump_done", bus_h.done, 1);
    checkOutput("run_jump_addr",  bus_w.addr, 20);

    // Restart from DONE; start ignored while running.
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    checkOutput("restart_done", bus_h.done, 0);
    checkOutput("restart_busy", bus_h.busy, 1);
    checkOutput("run_start_addr", bus_w.addr, 20);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    checkOutput("restart_valid", bus_h.din_valid, 1);
    checkOutput("restart_addr",  bus_h.addr, 0);
    checkOutput("restart_din",   bus_h.DIN, 16'hA000);

    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    checkOutput("pre_rst_addr_h", bus_h.addr, 2);
    checkOutput("pre_rst_din_w",  bus_w.DIN, 16'hA016);

    // Asynchronous reset in the middle of a cycle while running.
    step_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_addr",  bus_h.addr, 0);
    checkOutput("async_din",   bus_w.DIN, 0);
    checkOutput("async_valid", bus_w.din_valid, 0);
    checkOutput("async_busy",  bus_h.busy, 0);

    tick();
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    checkOutput("retain_din_w", bus_w.DIN, 16'hA000);
    checkOutput("retain_din_h", bus_h.DIN, 16'hA000);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd7);
    checkOutput("retain_beef", bus_w.DIN, 16'hBEEF);
    jump_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/prog_mem_streamer.md
Name: prog_mem_streamer

Overview:
- Parametrised program memory with an integrated fetch sequencer. It supplies instruction words (DIN) and their address to the simple processor.
- It generalises the fixed 32x16 test memory: configurable width and depth, a runtime write/load port, and a consumer step handshake.
- Adds jump support and a wrap-or-halt end-of-program mode.
- Sits between the program loader/testbench and the processor's DIN input.

Parameters:
DATA_W, 16, instruction word width
ADDR_W, 5, address width; depth = 2**ADDR_W
WRAP, 1, 1: after last address continue at 0; 0: halt in DONE after last word consumed

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  write strobe for load port
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
start  input  1  begin streaming from address 0 (accepted in IDLE or DONE only)
step_en  input  1  consumer accepts current DIN; advance
jump_en  input  1  redirect fetch to jump_addr (RUN only)
jump_addr  input  ADDR_W  jump target
addr  output  ADDR_W  address of word currently on DIN
DIN  output  DATA_W  current instruction word (registered)
din_valid  output  1  DIN/addr hold a valid fetched word
busy  output  1  high in FETCH or RUN
done  output  1  high in DONE (WRAP=0 only)

Behaviour:
- Reset (async, reset_n low): state IDLE; addr=0, DIN=0, din_valid=0, busy=0, done=0.
- Memory array is not reset; contents are preserved across reset. Contents are undefined at power-up until written.
- A reset during RUN aborts immediately, and the array keeps its contents.
- Memory: 2**ADDR_W x DATA_W, synchronous write, synchronous read (1-cycle latency).
- Writes are accepted in every state when wr_en=1.
- Read/write to the same address in the same cycle: the read returns the old data (read-before-write).
- States: IDLE, FETCH, RUN, DONE.
- IDLE: outputs hold. start=1 -> read address 0, state FETCH.
- FETCH (exactly 1 cycle): DIN<=mem[0], addr<=0, din_valid<=1, state RUN.
- RUN, priority order per cycle:
  - jump_en=1: addr<=jump_addr; DIN<=mem[jump_addr] next cycle; din_valid stays 1. step_en is ignored that cycle.
  - step_en=1, addr<2**ADDR_W-1: addr<=addr+1; DIN<=mem[addr+1]; din_valid stays 1. Zero-bubble throughput: one word per cycle with step_en held high.
  - step_en=1, addr=2**ADDR_W-1, WRAP=1: addr<=0, DIN<=mem[0], remain in RUN.
  - step_en=1, addr=2**ADDR_W-1, WRAP=0: state DONE; din_valid<=0, done<=1. addr and DIN hold their last values.
  - neither: addr, DIN and din_valid hold (stall).
- The next read address is computed combinationally from state and controls, so DIN and addr update in the same edge.
- DONE: done=1, busy=0. start=1 -> done<=0, state FETCH (restart at 0). step_en and jump_en are ignored.
- start is ignored in FETCH and RUN. jump_en is ignored outside RUN.
- busy=1 exactly when state is FETCH or RUN.
- Address arithmetic is modulo 2**ADDR_W; there is no out-of-range address.

Test Plan:
- Reset: hold reset_n=0 for 20 ns with start=1 -> addr=0, DIN=0, din_valid=0, busy=0, done=0. Deassert, keep start=0 -> stays IDLE.
- Load/stream: write mem[i]=16'hA000+i for i=0..31. Pulse start -> after 2 edges din_valid=1, addr=0, DIN=16'hA000. Hold step_en=1 -> DIN=16'hA001, 16'hA002, ... one per cycle with no bubbles.
- Stall: during RUN at addr=5, drop step_en for 3 cycles -> addr=5 and DIN=16'hA005 held. Reassert -> addr=6, DIN=16'hA006.
- Wrap vs halt: WRAP=1, step past addr=31 -> addr=0, DIN=16'hA000, busy=1. WRAP=0, same stimulus -> done=1, din_valid=0, addr=31. start -> done=0, then DIN=16'hA000.
- Jump priority: at addr=3 assert jump_en=1, jump_addr=20, step_en=1 -> next addr=20, DIN=16'hA014. jump_en in IDLE -> no effect.
- Write collision / mid-run reset: write mem[7]=16'hBEEF in the same cycle as a step from 6 to 7 -> DIN=16'hA007; revisit via jump -> 16'hBEEF. Assert reset_n=0 mid-RUN -> outputs clear asynchronously; restart reads 16'hA000 (contents retained).
